// File: rtl/vga_pkg.sv
// Shared video-timing constants and types for the itf_vga source and its bench.
// Defaults describe 800x600@60 with a 40 MHz pixel clock.
package vga_pkg;

  localparam int unsigned CNT_W       = 11;
  localparam int unsigned RGB_W       = 12;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned HOR_PIXELS     = 800;
  localparam int unsigned HOR_FP         = 40;
  localparam int unsigned HOR_SYNC       = 128;
  localparam int unsigned HOR_BP         = 88;
  localparam int unsigned HOR_TOTAL      = HOR_PIXELS + HOR_FP + HOR_SYNC + HOR_BP;
  localparam int unsigned HOR_SYNC_START = HOR_PIXELS + HOR_FP;
  localparam int unsigned HOR_SYNC_END   = HOR_SYNC_START + HOR_SYNC;

  localparam int unsigned VER_PIXELS     = 600;
  localparam int unsigned VER_FP         = 1;
  localparam int unsigned VER_SYNC       = 4;
  localparam int unsigned VER_BP         = 23;
  localparam int unsigned VER_TOTAL      = VER_PIXELS + VER_FP + VER_SYNC + VER_BP;
  localparam int unsigned VER_SYNC_START = VER_PIXELS + VER_FP;
  localparam int unsigned VER_SYNC_END   = VER_SYNC_START + VER_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  // One axis of the raster: position plus the flags that describe it.
  typedef struct packed {
    cnt_t count;
    logic blank;
    logic sync;
  } axis_t;

  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/itf_vga.sv
// Video stream bundle passed between the timing source and the draw_* pipeline stages.
interface itf_vga;

  vga_pkg::cnt_t                   vcount;
  logic                            vsync;
  logic                            vblnk;
  vga_pkg::cnt_t                   hcount;
  logic                            hsync;
  logic                            hblnk;
  logic [vga_pkg::RGB_W-1:0]       rgb;

  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with registered blank/sync flags
// derived from the next count, so flags and count always describe the same pixel.
module vga_axis_cnt
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL      = HOR_TOTAL,
  parameter int unsigned ACTIVE     = HOR_PIXELS,
  parameter int unsigned SYNC_START = HOR_SYNC_START,
  parameter int unsigned SYNC_LEN   = HOR_SYNC,
  parameter logic        POL        = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output cnt_t count_o,
  output logic blank_o,
  output logic sync_o,
  output logic wrap_o
);

  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT_END = cnt_t'(ACTIVE);
  localparam cnt_t SYNC_LO = cnt_t'(SYNC_START);
  localparam cnt_t SYNC_HI = cnt_t'(SYNC_START + SYNC_LEN);

  axis_t axis_q, axis_d;
  cnt_t  count_nxt;
  logic  at_last;

  // Out-of-range values (upset state) are treated like the last position and wrap to 0.
  assign at_last = (axis_q.count >= LAST);

  // NOTE: combinational blocks assign a default to every output first so no latch is inferred.
  always_comb begin
    axis_d    = axis_q;
    count_nxt = at_last ? '0 : axis_q.count + 1'b1;
    if (en_i) begin
      axis_d.count = count_nxt;
      axis_d.blank = (count_nxt >= ACT_END);
      axis_d.sync  = in_window(count_nxt, SYNC_LO, SYNC_HI) ? POL : ~POL;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axis_q.count <= '0;
      axis_q.blank <= 1'b0;
      axis_q.sync  <= ~POL;
    end else begin
      axis_q <= axis_d;
    end
  end

  assign count_o = axis_q.count;
  assign blank_o = axis_q.blank;
  assign sync_o  = axis_q.sync;
  assign wrap_o  = en_i & at_last;

endmodule

// File: rtl/vga_timing_gen.sv
// Origin of video timing for the draw pipeline: raster counters, sync/blank flags,
// a one-cycle frame_start strobe and a completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HOR_PIXELS,
  parameter int unsigned H_FP     = HOR_SYNC_START - HOR_PIXELS,
  parameter int unsigned H_SYNC   = HOR_SYNC_END - HOR_SYNC_START,
  parameter int unsigned H_BP     = HOR_TOTAL - HOR_SYNC_END,
  parameter int unsigned V_ACTIVE = VER_PIXELS,
  parameter int unsigned V_FP     = VER_SYNC_START - VER_PIXELS,
  parameter int unsigned V_SYNC   = VER_SYNC_END - VER_SYNC_START,
  parameter int unsigned V_BP     = VER_TOTAL - VER_SYNC_END,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_en,
  itf_vga.out                    out,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  cnt_t h_count, v_count;
  logic h_blank, h_sync, h_wrap;
  logic v_blank, v_sync, v_wrap;

  logic                   frame_start_q, frame_start_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  vga_axis_cnt #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .POL        (SYNC_POL)
  ) u_h_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (pix_en),
    .count_o (h_count),
    .blank_o (h_blank),
    .sync_o  (h_sync),
    .wrap_o  (h_wrap)
  );

  // The vertical axis steps only on the pixel that ends a line.
  vga_axis_cnt #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .POL        (SYNC_POL)
  ) u_v_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (pix_en & h_wrap),
    .count_o (v_count),
    .blank_o (v_blank),
    .sync_o  (v_sync),
    .wrap_o  (v_wrap)
  );

  // v_wrap already implies pix_en, so a stalled cycle always clears the strobe.
  always_comb begin
    frame_start_d = v_wrap;
    frame_cnt_d   = frame_cnt_q;
    if (v_wrap) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign out.hcount  = h_count;
  assign out.hblnk   = h_blank;
  assign out.hsync   = h_sync;
  assign out.vcount  = v_count;
  assign out.vblnk   = v_blank;
  assign out.vsync   = v_sync;
  assign out.rgb     = '0;

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size line timing on a default build, frame-level behaviour on
// reduced-size builds of both sync polarities (32x20 raster, 640 clk per frame).
`timescale 1ns/1ps
module tb_vga_timing_gen;
  import vga_pkg::*;

  // Reduced raster: H 16+4+8+4 = 32 (hsync 20..27), V 12+1+4+3 = 20 (vsync 13..16).
  localparam int SH_TOT = 32;
  localparam int SV_TOT = 20;
  localparam int FRAME  = SH_TOT * SV_TOT;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pix_en = 1'b0;

  itf_vga vga_def ();
  itf_vga vga_sml ();
  itf_vga vga_neg ();

  logic        fs_def, fs_sml, fs_neg;
  logic [15:0] fc_def, fc_sml, fc_neg;

  vga_timing_gen u_def (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .out         (vga_def),
    .frame_start (fs_def),
    .frame_cnt   (fc_def)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (12), .V_FP (1), .V_SYNC (4), .V_BP (3),
    .SYNC_POL (1'b1)
  ) u_sml (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .out         (vga_sml),
    .frame_start (fs_sml),
    .frame_cnt   (fc_sml)
  );

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (4), .H_SYNC (8), .H_BP (4),
    .V_ACTIVE (12), .V_FP (1), .V_SYNC (4), .V_BP (3),
    .SYNC_POL (1'b0)
  ) u_neg (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_en      (pix_en),
    .out         (vga_neg),
    .frame_start (fs_neg),
    .frame_cnt   (fc_neg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference raster position for the reduced builds.
  int mh = 0, mv = 0, mfc = 0;
  logic mfs = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; mfc = 0; mfs = 1'b0;
  endtask

  task automatic check_sml();
    logic hb, hs, vb, vs;
    hb = (mh >= 16);
    hs = (mh >= 20) && (mh <= 27);
    vb = (mv >= 12);
    vs = (mv >= 13) && (mv <= 16);
    check("sml_pos", {vga_sml.hcount, vga_sml.vcount}, {11'(mh), 11'(mv)});
    check("sml_flags", {vga_sml.hblnk, vga_sml.hsync, vga_sml.vblnk, vga_sml.vsync, fs_sml},
          {hb, hs, vb, vs, mfs});
    check("sml_fcnt", fc_sml, 16'(mfc));
    check("neg_sync", {vga_neg.hsync, vga_neg.vsync}, {~hs, ~vs});
  endtask

  // One clock edge with whatever pix_en is currently driven, then compare.
  task automatic tick();
    logic en;
    en = pix_en;
    adv(1);
    mfs = 1'b0;
    if (en) begin
      if (mh == SH_TOT - 1) begin
        mh = 0;
        if (mv == SV_TOT - 1) begin
          mv = 0;
          mfs = 1'b1;
          mfc++;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
    check_sml();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pos"}, {vga_sml.hcount, vga_sml.vcount}, 22'd0);
    check({tag, "_flags"}, {vga_sml.hblnk, vga_sml.hsync, vga_sml.vblnk, vga_sml.vsync, fs_sml}, 5'b0);
    check({tag, "_fcnt"}, fc_sml, 16'd0);
    check({tag, "_neg_sync"}, {vga_neg.hsync, vga_neg.vsync}, 2'b11);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int last_fs;
    int cyc;

    // ---- Reset state on the full-size build ----
    rst_n  = 1'b0;
    pix_en = 1'b0;
    adv(3);
    rst_n = 1'b1;
    check("def_rst_hcount", vga_def.hcount, 11'd0);
    check("def_rst_vcount", vga_def.vcount, 11'd0);
    check("def_rst_flags", {vga_def.hsync, vga_def.vsync, vga_def.hblnk, vga_def.vblnk}, 4'b0000);
    check("def_rst_rgb", vga_def.rgb, 12'h000);
    check("def_rst_fs", fs_def, 1'b0);
    check("def_rst_fcnt", fc_def, 16'd0);
    check("neg_rst_sync", {vga_neg.hsync, vga_neg.vsync}, 2'b11);

    // ---- pix_en low: everything holds ----
    for (int i = 0; i < 10; i++) begin
      adv(1);
      check("def_hold", {vga_def.hcount, vga_def.vcount, vga_def.hsync, vga_def.vsync,
                         vga_def.hblnk, vga_def.vblnk, fs_def}, 29'd0);
    end

    // ---- Full-size line timing ----
    pix_en = 1'b1;
    adv(1);
    check("def_first_step", {vga_def.hcount, vga_def.hblnk}, {11'd1, 1'b0});
    adv(798);
    check("def_h799", {vga_def.hcount, vga_def.hblnk, vga_def.hsync}, {11'd799, 1'b0, 1'b0});
    adv(1);
    check("def_h800", {vga_def.hcount, vga_def.hblnk, vga_def.hsync}, {11'd800, 1'b1, 1'b0});
    adv(39);
    check("def_h839", {vga_def.hcount, vga_def.hsync}, {11'd839, 1'b0});
    adv(1);
    check("def_h840", {vga_def.hcount, vga_def.hsync}, {11'd840, 1'b1});
    adv(127);
    check("def_h967", {vga_def.hcount, vga_def.hsync}, {11'd967, 1'b1});
    adv(1);
    check("def_h968", {vga_def.hcount, vga_def.hsync}, {11'd968, 1'b0});
    adv(87);
    check("def_h1055", {vga_def.hcount, vga_def.vcount, vga_def.hblnk}, {11'd1055, 11'd0, 1'b1});
    adv(1);
    check("def_line_wrap", {vga_def.hcount, vga_def.vcount, vga_def.hblnk, vga_def.vblnk, fs_def},
          {11'd0, 11'd1, 1'b0, 1'b0, 1'b0});

    // ---- Reduced build: three free-running frames ----
    pix_en = 1'b0;
    rst_n  = 1'b0;
    adv(2);
    rst_n = 1'b1;
    model_reset();
    check_sml();
    pix_en  = 1'b1;
    last_fs = -1;
    for (cyc = 1; cyc <= 3 * FRAME; cyc++) begin
      tick();
      if (fs_sml) begin
        if (last_fs >= 0) check("fs_gap", 32'(cyc - last_fs), 32'(FRAME));
        last_fs = cyc;
      end
    end
    check("three_frames", {vga_sml.hcount, vga_sml.vcount, fs_sml, fc_sml},
          {11'd0, 11'd0, 1'b1, 16'd3});
    check("sml_rgb", vga_sml.rgb, 12'h000);

    // ---- Random stalls ----
    for (int i = 0; i < 1500; i++) begin
      pix_en = 1'($urandom_range(0, 1));
      tick();
    end

    // ---- Asynchronous reset inside both sync pulses at (22,14) ----
    pix_en = 1'b1;
    for (int i = 0; i < 2 * FRAME && !(mh == 22 && mv == 14); i++) tick();
    check("pre_reset_sync", {vga_sml.hcount, vga_sml.vcount, vga_sml.hsync, vga_sml.vsync},
          {11'd22, 11'd14, 1'b1, 1'b1});
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("async_rst");
    adv(1);
    check_reset_state("held_rst");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME; i++) tick();
    check("post_rst_wrap", {vga_sml.hcount, vga_sml.vcount, fs_sml, fc_sml},
          {11'd0, 11'd0, 1'b1, 16'd1});
    check("neg_fcnt", fc_neg, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
